// File: rtl/xor_pair_match_pipe.sv
// Purpose: per-bit selectable XOR-pair match function with an elastic pipeline and an output toggle counter.
// Latency: STAGES cycles from input accept to result valid; one word per cycle sustained.
// Backpressure: valid/ready chain; in_ready follows out_ready combinationally, stalled stages hold data.
module xor_pair_match_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             hit,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] toggle_cnt
);

  localparam int PCW   = $clog2(WIDTH + 1);
  localparam int SUM_W = ((CNT_W > PCW) ? CNT_W : PCW) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0]  t1, t2, f;
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] adv;
  logic [WIDTH-1:0]  dat [STAGES];
  logic [WIDTH-1:0]  last_y;
  logic [WIDTH-1:0]  diff;
  logic [PCW-1:0]    pop;
  logic [SUM_W-1:0]  sum;
  logic [CNT_W-1:0]  cnt_sat;
  logic              out_hs;

  // Match function, evaluated on the operands as presented
  always_comb begin
    t1 = a ^ d;
    t2 = a ^ (b & c);
    case (mode)
      2'd0:    f = t1 & t2;
      2'd1:    f = t1;
      2'd2:    f = t2;
      default: f = t1 | t2;
    endcase
  end

  // A stage may advance unless it and every stage after it are full while the sink stalls
  always_comb begin
    logic full_tail;
    full_tail = 1'b1;
    adv       = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      full_tail = full_tail & v[i];
      adv[i]    = out_ready | ~full_tail;
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = v[STAGES-1];
  assign y         = dat[STAGES-1];
  assign hit       = |y;
  assign out_hs    = out_valid & out_ready;

  // Pipeline valid/data registers; data only moves with a valid word to avoid idle toggling
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
      for (int i = 0; i < STAGES; i++) dat[i] <= '0;
    end else begin
      if (adv[0]) v[0] <= in_valid;
      if (adv[0] && in_valid) dat[0] <= f;
      for (int i = 1; i < STAGES; i++) begin
        if (adv[i]) begin
          v[i] <= v[i-1];
          if (v[i-1]) dat[i] <= dat[i-1];
        end
      end
    end
  end

  // Hamming distance between the emitted word and the previous one, with saturating add
  always_comb begin
    diff = y ^ last_y;
    pop  = '0;
    for (int i = 0; i < WIDTH; i++) pop = pop + PCW'(diff[i]);
    sum     = SUM_W'(toggle_cnt) + SUM_W'(pop);
    cnt_sat = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
  end

  // Toggle counter and previous-output history; clear wins over a same-edge increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      toggle_cnt <= '0;
      last_y     <= '0;
    end else begin
      if (out_hs) last_y <= y;
      if (clr_cnt)     toggle_cnt <= '0;
      else if (out_hs) toggle_cnt <= cnt_sat;
    end
  end

endmodule

// File: tb/tb_xor_pair_match_pipe.sv
// Bench for xor_pair_match_pipe: WIDTH=8, STAGES=3, CNT_W=4.
// Table-driven function vectors plus directed throughput, backpressure, saturation and reset sequences.
module tb_xor_pair_match_pipe;
  localparam int W  = 8;
  localparam int S  = 3;
  localparam int CW = 4;

  logic          clk, rst;
  logic          in_valid, in_ready, out_valid, out_ready, hit, clr_cnt;
  logic [W-1:0]  a, b, c, d, y;
  logic [1:0]    mode;
  logic [CW-1:0] toggle_cnt;

  xor_pair_match_pipe #(.WIDTH(W), .STAGES(S), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .d(d), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .hit(hit),
    .clr_cnt(clr_cnt), .toggle_cnt(toggle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Handshakes that will happen on the coming rising edge
  logic [W-1:0] got_q [$];
  int got_c [$];
  int acc_c [$];
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        got_q.push_back(y);
        got_c.push_back(cyc);
      end
      if (in_valid && in_ready) acc_c.push_back(cyc);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q;
    got_q.delete();
    got_c.delete();
    acc_c.delete();
  endtask

  // Push one word into an empty pipe, wait for it, then handshake it (optionally with clr_cnt)
  task automatic emit_one(input logic [1:0] m, input logic [W-1:0] ia, ib, ic, id, input logic clr,
                          output logic [W-1:0] oy, output logic oh, output logic [CW-1:0] oc,
                          output int lat);
    mode = m; a = ia; b = ib; c = ic; d = id;
    in_valid = 1'b1; out_ready = 1'b0;
    tick;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick;
      lat++;
    end
    oy = y; oh = hit;
    clr_cnt = clr; out_ready = 1'b1;
    tick;
    out_ready = 1'b0; clr_cnt = 1'b0;
    oc = toggle_cnt;
  endtask

  typedef struct {
    logic [1:0]    m;
    logic [W-1:0]  a, b, c, d;
    logic [W-1:0]  ey;
    logic          eh;
    logic [CW-1:0] ec;
  } vec_t;

  vec_t tbl [8];
  logic [W-1:0]  tw [10];
  logic [W-1:0]  bw [5];
  logic [W-1:0]  ry;
  logic          rh;
  logic [CW-1:0] rc;
  int            rl;
  int            idx;

  initial begin
    tbl[0] = '{2'd0, 8'hF0, 8'hFF, 8'h0F, 8'h0F, 8'hFF, 1'b1, 4'd8};
    tbl[1] = '{2'd0, 8'hAA, 8'hFF, 8'hFF, 8'h55, 8'h55, 1'b1, 4'd12};
    tbl[2] = '{2'd1, 8'h0F, 8'h00, 8'h00, 8'h0F, 8'h00, 1'b0, 4'd15};
    tbl[3] = '{2'd2, 8'h3C, 8'hF0, 8'h0F, 8'h00, 8'h3C, 1'b1, 4'd15};
    tbl[4] = '{2'd3, 8'h81, 8'h00, 8'h00, 8'h81, 8'h81, 1'b1, 4'd15};
    tbl[5] = '{2'd2, 8'h00, 8'hCC, 8'hAA, 8'hFF, 8'h88, 1'b1, 4'd15};
    tbl[6] = '{2'd0, 8'h0F, 8'h33, 8'h55, 8'hF0, 8'h1E, 1'b1, 4'd15};
    tbl[7] = '{2'd3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 4'd15};
    tw = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h10, 8'h32};
    bw = '{8'hC1, 8'h3E, 8'h7F, 8'h80, 8'h5A};

    in_valid = 0; out_ready = 0; clr_cnt = 0; mode = 0; a = 0; b = 0; c = 0; d = 0;
    rst = 1'b1;
    repeat (2) tick;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_y", 32'(y), 0);
    chk("rst_hit", 32'(hit), 0);
    chk("rst_cnt", 32'(toggle_cnt), 0);
    rst = 1'b0;
    tick;
    chk("rst_in_ready", 32'(in_ready), 1);

    // Toggle counting with clear on the same edge as a handshake
    emit_one(2'd0, 8'hF0, 8'hFF, 8'h0F, 8'h0F, 1'b0, ry, rh, rc, rl);
    chk("tog1_y", 32'(ry), 32'hFF);
    chk("tog1_cnt", 32'(rc), 8);
    chk("latency", 32'(rl), S - 1);
    emit_one(2'd0, 8'hAA, 8'hFF, 8'hFF, 8'h55, 1'b0, ry, rh, rc, rl);
    chk("tog2_cnt", 32'(rc), 12);
    emit_one(2'd1, 8'h0F, 8'h00, 8'h00, 8'h0F, 1'b1, ry, rh, rc, rl);
    chk("tog3_y", 32'(ry), 0);
    chk("tog3_clr_cnt", 32'(rc), 0);
    emit_one(2'd3, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0, ry, rh, rc, rl);
    chk("tog4_last_y_zero", 32'(rc), 8);

    // Saturation from a fresh reset
    rst = 1'b1; tick; rst = 1'b0; tick;
    emit_one(2'd3, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, ry, rh, rc, rl);
    chk("sat0", 32'(rc), 0);
    emit_one(2'd3, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0, ry, rh, rc, rl);
    chk("sat8", 32'(rc), 8);
    emit_one(2'd3, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, ry, rh, rc, rl);
    chk("sat_clamp", 32'(rc), 15);
    emit_one(2'd3, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0, ry, rh, rc, rl);
    chk("sat_hold", 32'(rc), 15);
    clr_cnt = 1'b1; tick; clr_cnt = 1'b0;
    chk("clr_alone", 32'(toggle_cnt), 0);
    emit_one(2'd3, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, ry, rh, rc, rl);
    chk("post_clr", 32'(rc), 8);
    rst = 1'b1; tick; rst = 1'b0; tick;

    // Function table
    for (int i = 0; i < 8; i++) begin
      emit_one(tbl[i].m, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d, 1'b0, ry, rh, rc, rl);
      chk($sformatf("tbl%0d_y", i), 32'(ry), 32'(tbl[i].ey));
      chk($sformatf("tbl%0d_hit", i), 32'(rh), 32'(tbl[i].eh));
      chk($sformatf("tbl%0d_cnt", i), 32'(rc), 32'(tbl[i].ec));
    end

    // Throughput: 10 back-to-back words, out_ready held high
    clear_q();
    out_ready = 1'b1; mode = 2'd1; b = 0; c = 0; d = 0;
    for (int k = 0; k < 10; k++) begin
      a = tw[k]; in_valid = 1'b1;
      tick;
    end
    in_valid = 1'b0;
    for (int n = 0; n < 20 && got_q.size() < 10; n++) tick;
    chk("thr_count", 32'(got_q.size()), 10);
    chk("thr_acc", 32'(acc_c.size()), 10);
    if (got_q.size() == 10 && acc_c.size() == 10) begin
      for (int k = 0; k < 10; k++) begin
        chk($sformatf("thr%0d_y", k), 32'(got_q[k]), 32'(tw[k]));
        chk($sformatf("thr%0d_lat", k), 32'(got_c[k] - acc_c[k]), S);
        chk($sformatf("thr%0d_gap", k), 32'(got_c[k] - got_c[0]), 32'(k));
      end
    end

    // Backpressure: out_ready low while offering 5 words
    clear_q();
    out_ready = 1'b0;
    idx = 0;
    for (int n = 0; n < 8; n++) begin
      if (idx < 5) begin in_valid = 1'b1; a = bw[idx]; end else in_valid = 1'b0;
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      tick;
    end
    chk("bp_accepted", 32'(acc_c.size()), 3);
    chk("bp_in_ready", 32'(in_ready), 0);
    chk("bp_out_valid", 32'(out_valid), 1);
    chk("bp_y", 32'(y), 32'(bw[0]));
    repeat (3) tick;
    chk("bp_y_stable", 32'(y), 32'(bw[0]));
    out_ready = 1'b1;
    #1;
    chk("bp_ready_follow", 32'(in_ready), 1);
    for (int n = 0; n < 30 && got_q.size() < 5; n++) begin
      if (idx < 5) begin in_valid = 1'b1; a = bw[idx]; end else in_valid = 1'b0;
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      tick;
    end
    in_valid = 1'b0;
    repeat (5) tick;
    chk("bp_count", 32'(got_q.size()), 5);
    if (got_q.size() == 5)
      for (int k = 0; k < 5; k++) chk($sformatf("bp%0d_y", k), 32'(got_q[k]), 32'(bw[k]));

    // Reset with two words in flight
    out_ready = 1'b0;
    a = 8'h5A; in_valid = 1'b1; tick;
    a = 8'hA5; tick;
    in_valid = 1'b0;
    chk("pre_rst_cnt", 32'(toggle_cnt), 15);
    clear_q();
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_y", 32'(y), 0);
    chk("mid_rst_cnt", 32'(toggle_cnt), 0);
    tick;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (10) tick;
    chk("mid_rst_no_stale", 32'(got_q.size()), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/xor_pair_match_pipe.md
# xor_pair_match_pipe

Parametrised, pipelined, elastic successor to the 4-input XOR-pair match cell in the power sub-circuit set. Each of WIDTH bit-slices evaluates a selectable XOR-pair function of operands a, b, c, d. Results pass through a STAGES-deep valid/ready pipeline. A saturating toggle counter accumulates output switching activity for power-experiment characterisation.

## Interface
- WIDTH, 8: bit-slices per operand/result (≥1)
- STAGES, 2: pipeline register stages (1..4)
- CNT_W, 16: toggle counter width (≥4)

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand word valid
- in_ready  out  1  block can accept operands
- a, b, c, d  in  WIDTH each  operands
- mode  in  2  function select, sampled with operands
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- y  out  WIDTH  result word
- hit  out  1  |y, aligned with y
- clr_cnt  in  1  synchronous clear of toggle counter
- toggle_cnt  out  CNT_W  accumulated output Hamming distance

## Operation
- Per bit i: t1 = a^d, t2 = a^(b&c). mode 0: y = t1&t2 (base function); 1: y = t1; 2: y = t2; 3: y = t1|t2.
- Function is evaluated combinationally at input and registered into stage 0 on accept (in_valid&in_ready). Stages 1..STAGES-1 are pure delay. y/hit/out_valid come from the last stage.
- Each stage holds a valid bit. A stage advances when it is empty or the next stage advances; the last stage advances on out_ready or when empty.
- in_ready = ~v[0] | adv[0] (combinational from out_ready through the chain; no combinational path from in_valid to in_ready).
- Full throughput: one word per cycle while out_ready=1. No bubbles inserted, none lost.
- Data and valid in a stalled stage hold stable. y does not change while out_valid=1 and out_ready=0.
- Toggle counter: on each output handshake (out_valid&out_ready), toggle_cnt += popcount(y ^ last_y), then last_y ← y. Saturates at 2^CNT_W−1 and never wraps.
- clr_cnt=1: toggle_cnt ← 0 on that edge and has priority over a simultaneous handshake increment. last_y still updates on that handshake.

## Timing
- Reset (async assert, sync release) clears: all stage valids=0, stage data=0, y=0, hit=0, out_valid=0, toggle_cnt=0, last_y=0. in_ready=1 in the first cycle after reset.
- Latency: word accepted at edge t shows out_valid=1 with its y after edge t+STAGES−1, i.e. STAGES cycles input-to-output.
- Reset mid-operation: all in-flight words are discarded and none appear after release. The counter returns to 0.
- Full pipeline with out_ready=0: in_ready=0. When out_ready rises, in_ready rises in the same cycle, so accept and emit occur on the same edge.
- Simultaneous accept and emit on an otherwise full pipeline: occupancy stays unchanged.
- Saturation: an increment that would exceed the max clamps to the max. Further handshakes leave toggle_cnt at the max until clr_cnt or rst.

## Test plan
- Function check (WIDTH=8, mode 0): a=0xF0, b=0xFF, c=0x0F, d=0x0F → y=0xFF, hit=1. Then a=0xAA, b=0xFF, c=0xFF, d=0x55 → y=0x55. Then mode 1 with a=0x0F, d=0x0F → y=0x00, hit=0.
- Toggle count: emit 0xFF then 0x55 from reset → toggle_cnt=8 then 12. Assert clr_cnt together with a third handshake of 0x00 → toggle_cnt=0 and last_y=0x00.
- Latency/throughput (STAGES=3, out_ready=1): 10 back-to-back words → first out_valid 3 cycles after first accept, then 10 consecutive valid cycles in order.
- Backpressure: hold out_ready=0 while sending 5 words → exactly 3 accepted, then in_ready=0 and y stable. Release out_ready → all 5 emerge in order with none duplicated.
- Saturation (CNT_W=4): emit 0x00, 0xFF, 0x00 → toggle_cnt 0, 8, 15 (clamped), stays 15 on further toggles.
- Reset mid-stream: assert rst with 2 words in flight → out_valid=0, y=0, toggle_cnt=0 immediately. After release, no stale word appears and in_ready=1.
